// File: rtl/csd_pkg.sv
// Shared types, default sizes and lane-slice helpers for the CSD vector unit.
package csd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int DEF_NUM_LANES   = 4;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_ACCUM_WIDTH = 48;
    localparam int DEF_LEN_WIDTH   = 16;

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/csd_vector_unit_if.sv
// Job descriptor, operand beat and result channels of the CSD vector unit.
interface csd_vector_unit_if #(
    parameter int NUM_LANES   = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ACCUM_WIDTH = 48,
    parameter int LEN_WIDTH   = 16
);
    logic                            cfg_valid;
    logic                            cfg_ready;
    logic [LEN_WIDTH-1:0]            cfg_len;
    logic                            cfg_mode;
    logic [NUM_LANES-1:0]            cfg_break_mask;
    logic                            in_valid;
    logic                            in_ready;
    logic [NUM_LANES*DATA_WIDTH-1:0] in_act;
    logic [NUM_LANES*DATA_WIDTH-1:0] in_wgt;
    logic [NUM_LANES-1:0]            in_nz_mask;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_LANES*ACCUM_WIDTH-1:0] out_data;
    logic [NUM_LANES-1:0]            out_seg_mask;
    logic                            busy;

    modport master (
        output cfg_valid, cfg_len, cfg_mode, cfg_break_mask,
        output in_valid, in_act, in_wgt, in_nz_mask, out_ready,
        input  cfg_ready, in_ready, out_valid, out_data,
        input  out_seg_mask, busy
    );

    modport slave (
        input  cfg_valid, cfg_len, cfg_mode, cfg_break_mask,
        input  in_valid, in_act, in_wgt, in_nz_mask, out_ready,
        output cfg_ready, in_ready, out_valid, out_data,
        output out_seg_mask, busy
    );
endinterface

// File: rtl/csd_lane_mac.sv
// One lane: signed multiply, zero-skip gate and wrapping accumulator.
module csd_lane_mac #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACCUM_WIDTH = 48
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr_i,
    input  logic                          en_i,
    input  logic                          nz_i,
    input  logic signed [DATA_WIDTH-1:0]  act_i,
    input  logic signed [DATA_WIDTH-1:0]  wgt_i,
    output logic [ACCUM_WIDTH-1:0]        acc_o
);
    logic signed [2*DATA_WIDTH-1:0]  prod;
    logic signed [ACCUM_WIDTH-1:0]   acc_q;
    logic signed [ACCUM_WIDTH-1:0]   acc_d;

    assign prod = act_i * wgt_i;

    always_comb begin
        acc_d = acc_q;
        if (clr_i)
            acc_d = '0;
        else if (en_i && nz_i)
            acc_d = acc_q + ACCUM_WIDTH'(prod);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/csd_vector_unit.sv
// Lane-parallel MAC job engine with a segmented cascade drained one lane per cycle.
module csd_vector_unit
    import csd_pkg::*;
#(
    parameter int NUM_LANES   = DEF_NUM_LANES,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ACCUM_WIDTH = DEF_ACCUM_WIDTH,
    parameter int LEN_WIDTH   = DEF_LEN_WIDTH
) (
    input logic              clk,
    input logic              rst_n,
    csd_vector_unit_if.slave bus
);
    localparam int KW = $clog2(NUM_LANES);
    localparam logic [KW-1:0]        K1   = KW'(1);
    localparam logic [KW-1:0]        KEND = KW'(NUM_LANES - 1);
    localparam logic [LEN_WIDTH-1:0] L1   = LEN_WIDTH'(1);

    state_e                 st_q, st_d;
    logic [LEN_WIDTH-1:0]   len_q, cnt_q;
    logic                   mode_q;
    logic [NUM_LANES-1:0]   brk_q, eff_brk;
    logic [KW-1:0]          k_q;
    logic [ACCUM_WIDTH-1:0] acc    [NUM_LANES];
    logic [ACCUM_WIDTH-1:0] casc_q [NUM_LANES];
    logic [ACCUM_WIDTH-1:0] casc_in;
    logic                   cfg_hs, beat_hs, last_beat, last_lane;

    assign cfg_hs    = bus.cfg_valid && (st_q == ST_IDLE);
    assign beat_hs   = bus.in_valid && (st_q == ST_RUN);
    assign last_beat = beat_hs && ((cnt_q + L1) == len_q);
    assign last_lane = (k_q == KEND);
    assign eff_brk   = mode_q ? brk_q : '0;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        csd_lane_mac #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACCUM_WIDTH(ACCUM_WIDTH)
        ) u_mac (
            .clk  (clk),
            .rst_n(rst_n),
            .clr_i(cfg_hs),
            .en_i (beat_hs),
            .nz_i (bus.in_nz_mask[g]),
            .act_i(bus.in_act[lane_lo(g, DATA_WIDTH) +: DATA_WIDTH]),
            .wgt_i(bus.in_wgt[lane_lo(g, DATA_WIDTH) +: DATA_WIDTH]),
            .acc_o(acc[g])
        );

        assign bus.out_data[lane_lo(g, ACCUM_WIDTH) +: ACCUM_WIDTH] =
            bus.out_seg_mask[g] ? casc_q[g] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            st_q <= ST_IDLE;
        else
            st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            ST_IDLE:  if (bus.cfg_valid)
                          st_d = (bus.cfg_len == '0) ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (last_beat) st_d = ST_DRAIN;
            ST_DRAIN: if (last_lane) st_d = ST_DONE;
            ST_DONE:  if (bus.out_ready) st_d = ST_IDLE;
            default:  st_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.cfg_ready    = (st_q == ST_IDLE);
        bus.in_ready     = (st_q == ST_RUN);
        bus.out_valid    = (st_q == ST_DONE);
        bus.busy         = (st_q != ST_IDLE);
        bus.out_seg_mask = '0;
        if (st_q == ST_DONE)
            bus.out_seg_mask = {1'b1, eff_brk[NUM_LANES-2:0]};
    end

    // Lane k adds its left neighbour's partial sum unless a break separates them.
    always_comb begin
        casc_in = '0;
        if ((k_q != '0) && !eff_brk[k_q - K1])
            casc_in = casc_q[k_q - K1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q  <= '0;
            cnt_q  <= '0;
            mode_q <= 1'b0;
            brk_q  <= '0;
            k_q    <= '0;
            for (int i = 0; i < NUM_LANES; i++)
                casc_q[i] <= '0;
        end else begin
            if (cfg_hs) begin
                len_q  <= bus.cfg_len;
                mode_q <= bus.cfg_mode;
                brk_q  <= bus.cfg_break_mask;
                cnt_q  <= '0;
                k_q    <= '0;
            end
            if (beat_hs)
                cnt_q <= cnt_q + L1;
            if (st_q == ST_DRAIN) begin
                casc_q[k_q] <= acc[k_q] + casc_in;
                k_q         <= k_q + K1;
            end
        end
    end
endmodule

// File: tb/tb_csd_vector_unit.sv
// Directed and randomized job checks of csd_vector_unit against a segment-sum model.
module tb_csd_vector_unit;
    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int AW   = 48;
    localparam int LW   = 16;
    localparam int DWID = N * AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csd_vector_unit_if #(
        .NUM_LANES(N), .DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .LEN_WIDTH(LW)
    ) bus ();

    csd_vector_unit #(
        .NUM_LANES(N), .DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .LEN_WIDTH(LW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int b_act [64][N];
    int b_wgt [64][N];
    bit b_nz  [64][N];
    logic [DWID-1:0] exp_data;
    logic [N-1:0]    exp_seg;
    bit saw_rdy;

    always @(negedge clk) if (bus.in_ready) saw_rdy = 1'b1;

    task automatic chk(input string tag, input logic [DWID-1:0] obs,
                       input logic [DWID-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Sum each lane over the job, then fold lanes left to right into segments.
    task automatic model(input int len, input bit mode, input logic [N-1:0] brk);
        longint acc [N];
        longint run;
        for (int i = 0; i < N; i++) begin
            acc[i] = 0;
            for (int b = 0; b < len; b++)
                if (b_nz[b][i]) acc[i] += longint'(b_act[b][i] * b_wgt[b][i]);
        end
        exp_data = '0;
        exp_seg  = '0;
        run      = 0;
        for (int i = 0; i < N; i++) begin
            run += acc[i];
            if (i == N - 1 || (mode && brk[i])) begin
                exp_seg[i] = 1'b1;
                exp_data[i*AW +: AW] = run[AW-1:0];
                run = 0;
            end
        end
    endtask

    task automatic send_cfg(input int len, input bit mode, input logic [N-1:0] brk);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.cfg_ready && t < 100) begin @(negedge clk); t++; end
        chk("cfg_wait", 192'(t < 100), 1);
        bus.cfg_valid = 1'b1;
        bus.cfg_len = LW'(len);
        bus.cfg_mode = mode;
        bus.cfg_break_mask = brk;
        @(posedge clk);
        #1 bus.cfg_valid = 1'b0;
    endtask

    task automatic send_beats(input int first, input int last, input bit gaps);
        int t;
        for (int b = first; b <= last; b++) begin
            t = 0;
            @(negedge clk);
            if (gaps && $urandom_range(0, 2) == 0) @(negedge clk);
            for (int i = 0; i < N; i++) begin
                bus.in_act[i*DW +: DW] = DW'(b_act[b][i]);
                bus.in_wgt[i*DW +: DW] = DW'(b_wgt[b][i]);
                bus.in_nz_mask[i] = b_nz[b][i];
            end
            bus.in_valid = 1'b1;
            while (!bus.in_ready && t < 100) begin @(negedge clk); t++; end
            chk("beat_wait", 192'(t < 100), 1);
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
        end
    endtask

    task automatic finish_job(input string tag, input int hold, input bit no_rdy);
        int lat;
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 200) begin @(negedge clk); lat++; end
        chk({tag, "_latency"}, lat, N);
        chk({tag, "_data"}, bus.out_data, exp_data);
        chk({tag, "_seg"}, bus.out_seg_mask, exp_seg);
        chk({tag, "_busy"}, bus.busy, 1);
        if (no_rdy) chk({tag, "_no_in_ready"}, saw_rdy, 0);
        if (hold > 0) begin
            bus.cfg_valid = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk({tag, "_hold_valid"}, bus.out_valid, 1);
                chk({tag, "_hold_data"}, bus.out_data, exp_data);
                chk({tag, "_hold_seg"}, bus.out_seg_mask, exp_seg);
            end
            bus.cfg_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_cfg_ready"}, bus.cfg_ready, 1);
        chk({tag, "_idle_busy"}, bus.busy, 0);
        chk({tag, "_idle_valid"}, bus.out_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cfg_ready"}, bus.cfg_ready, 1);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_seg"}, bus.out_seg_mask, 0);
    endtask

    task automatic fill_beat(input int b, input int a0, input int a1, input int a2,
                             input int a3, input int w0, input int w1, input int w2,
                             input int w3, input logic [N-1:0] nz);
        b_act[b] = '{a0, a1, a2, a3};
        b_wgt[b] = '{w0, w1, w2, w3};
        for (int i = 0; i < N; i++) b_nz[b][i] = nz[i];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        bit mode;
        logic [N-1:0] brk;

        bus.cfg_valid = 1'b0;
        bus.cfg_len = '0;
        bus.cfg_mode = 1'b0;
        bus.cfg_break_mask = '0;
        bus.in_valid = 1'b0;
        bus.in_act = '0;
        bus.in_wgt = '0;
        bus.in_nz_mask = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Dense single beat: 5+12+21+32 lands on the last lane.
        fill_beat(0, 1, 2, 3, 4, 5, 6, 7, 8, 4'b1111);
        exp_data = {48'd70, 144'd0};
        exp_seg  = 4'b1000;
        send_cfg(1, 1'b0, 4'b0000);
        send_beats(0, 0, 1'b0);
        finish_job("dense", 0, 1'b0);

        // Sparse with a break after lane 1: two segments of two lanes.
        fill_beat(0, 1, 1, 1, 1, 1, 2, 3, 4, 4'b1111);
        fill_beat(1, 1, 1, 1, 1, 1, 2, 3, 4, 4'b1111);
        exp_data = {48'd14, 48'd0, 48'd6, 48'd0};
        exp_seg  = 4'b1010;
        send_cfg(2, 1'b1, 4'b0010);
        send_beats(0, 1, 1'b0);
        finish_job("sparse", 0, 1'b0);

        // Zero-skip removes lanes 1 and 3.
        fill_beat(0, 10, 10, 10, 10, 1, 1, 1, 1, 4'b0101);
        exp_data = {48'd20, 144'd0};
        exp_seg  = 4'b1000;
        send_cfg(1, 1'b0, 4'b1111);
        send_beats(0, 0, 1'b0);
        finish_job("zskip", 0, 1'b0);

        // Empty job drains straight away.
        saw_rdy  = 1'b0;
        exp_data = '0;
        exp_seg  = 4'b1000;
        send_cfg(0, 1'b0, 4'b0000);
        finish_job("len0", 0, 1'b1);

        // Back-pressure in DONE with a stray descriptor pulse.
        fill_beat(0, -7, 33, 100, -128, 9, -2, 127, 3, 4'b1011);
        fill_beat(1, 50, -60, 70, -80, -1, 2, -3, 4, 4'b1111);
        model(2, 1'b1, 4'b0100);
        send_cfg(2, 1'b1, 4'b0100);
        send_beats(0, 1, 1'b0);
        finish_job("hold", 5, 1'b0);

        // Abort mid-job with reset, then run a fresh extreme-value job.
        fill_beat(0, 3, 3, 3, 3, 3, 3, 3, 3, 4'b1111);
        send_cfg(3, 1'b0, 4'b0000);
        send_beats(0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        chk("midreset_held_valid", bus.out_valid, 0);
        rst_n = 1'b1;
        fill_beat(0, -128, -128, -128, -128, -128, -128, -128, -128, 4'b1111);
        exp_data = {48'd65536, 144'd0};
        exp_seg  = 4'b1000;
        send_cfg(1, 1'b0, 4'b0000);
        send_beats(0, 0, 1'b0);
        finish_job("postreset", 0, 1'b0);

        for (int j = 0; j < 24; j++) begin
            len  = $urandom_range(0, 9);
            mode = 1'($urandom_range(0, 1));
            brk  = N'($urandom);
            for (int b = 0; b < len; b++)
                for (int i = 0; i < N; i++) begin
                    b_act[b][i] = int'($urandom_range(0, 255)) - 128;
                    b_wgt[b][i] = int'($urandom_range(0, 255)) - 128;
                    b_nz[b][i]  = 1'($urandom_range(0, 3) != 0);
                end
            model(len, mode, brk);
            saw_rdy = 1'b0;
            send_cfg(len, mode, brk);
            if (len > 0) send_beats(0, len - 1, 1'b1);
            finish_job("rand", $urandom_range(0, 2), len == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/csd_vector_unit.md
CSD_VECTOR_UNIT -- requirements
Module: csd_vector_unit

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: number of MAC lanes (DSP groups) in the chain, 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: signed activation/weight width per lane.
REQ-003 SHALL have parameter ACCUM_WIDTH, default 48: signed accumulator and cascade width, at least 2*DATA_WIDTH+LEN_WIDTH.
REQ-004 SHALL have parameter LEN_WIDTH, default 16: width of the job beat count.
REQ-005 SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-006 Ports SHALL be, clock and reset first:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- cfg_valid  in  1  job descriptor valid.
- cfg_ready  out  1  descriptor accepted when both are high.
- cfg_len  in  LEN_WIDTH  beats in the job.
- cfg_mode  in  1  0 = dense (one chain sum); 1 = sparse (segmented sums).
- cfg_break_mask  in  NUM_LANES  bit i=1 breaks the cascade between lane i and lane i+1; bit NUM_LANES-1 is ignored.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  beat accepted when both are high.
- in_act  in  NUM_LANES*DATA_WIDTH  signed activations, lane 0 in the LSBs.
- in_wgt  in  NUM_LANES*DATA_WIDTH  signed weights, lane 0 in the LSBs.
- in_nz_mask  in  NUM_LANES  bit i=0 gates the lane-i product to zero (zero-skip).
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when both are high.
- out_data  out  NUM_LANES*ACCUM_WIDTH  per-lane segment sums.
- out_seg_mask  out  NUM_LANES  bit i=1 means lane i holds a segment sum.
- busy  out  1  high in every state except IDLE.

Function
REQ-007 SHALL implement an FSM with states IDLE, RUN, DRAIN, DONE.
REQ-008 In IDLE: cfg_ready=1, in_ready=0. On a cfg handshake the block SHALL latch len, mode and break_mask, clear every accumulator, and enter RUN next cycle; if len=0 it SHALL enter DRAIN instead.
REQ-009 In RUN: in_ready=1 and cfg_ready=0. Each accepted beat SHALL update acc_i <= acc_i + sext(act_i*wgt_i) when nz_i=1, and leave acc_i unchanged otherwise. This update is single-cycle.
REQ-010 A beat counter SHALL count accepted beats; on the accept of beat number len, the block SHALL enter DRAIN.
REQ-011 in_valid outside RUN SHALL be ignored, with in_ready=0.
REQ-012 In DRAIN: eff_break = break_mask in sparse mode, all zeros in dense mode. Over NUM_LANES cycles, lane index k = 0..NUM_LANES-1, the block SHALL compute casc_k = acc_k + ((k==0 || eff_break[k-1]) ? 0 : casc_{k-1}), one lane per cycle.
REQ-013 After the final DRAIN cycle the block SHALL enter DONE with out_valid=1.
- Latency: last beat accepted in cycle t gives out_valid high in cycle t+NUM_LANES+1.
REQ-014 out_seg_mask[i] SHALL equal eff_break[i] for i<NUM_LANES-1; bit NUM_LANES-1 SHALL always be 1.
REQ-015 out_data lane i SHALL be casc_i when out_seg_mask[i]=1, and 0 otherwise.
REQ-016 All arithmetic SHALL be two's complement, wrapping modulo 2^ACCUM_WIDTH, with no saturation.
REQ-017 In DONE: out_data and out_seg_mask SHALL be held stable while out_ready=0. On the out handshake the block SHALL return to IDLE, and cfg_ready SHALL be 1 on the next cycle.
REQ-018 A cfg_valid pulse while busy=1 SHALL be ignored and SHALL not be latched.

Reset
REQ-019 rst_n low SHALL asynchronously force IDLE, clear accumulators, cascade registers and counters, and drive out_valid=0, in_ready=0, out_data=0, out_seg_mask=0, busy=0 and cfg_ready=1. This holds mid-job, and the aborted job produces no output.
REQ-020 Reset release SHALL be synchronous to clk; the first cfg handshake is possible on the first clk edge after release.

Structure
REQ-021 Package csd_pkg SHALL hold the FSM state enum, default parameter constants and the lane-slice helper functions.
REQ-022 The per-lane multiply/gate/accumulate SHALL be sub-module csd_lane_mac, instantiated NUM_LANES times. Cascade and FSM logic live in the top module.

Verification
REQ-023 Dense, N=4, len=1, act=[1,2,3,4], wgt=[5,6,7,8], nz=1111 -> lane3 out=70, seg_mask=1000, out_valid at t+5.
REQ-024 Sparse, break=0010, len=2, both beats act=[1,1,1,1], wgt=[1,2,3,4] -> lane1=6, lane3=14, others 0, seg_mask=1010.
REQ-025 nz_mask=0101 with act=[10,10,10,10], wgt=[1,1,1,1], dense -> lane3=20.
REQ-026 len=0 -> DRAIN directly; out all zeros, seg_mask=1000 in dense mode; in_ready never high.
REQ-027 out_ready held low 5 cycles in DONE -> out_data stable, cfg_valid ignored; after the handshake, IDLE next cycle.
REQ-028 rst_n low in RUN after beat 1 of len=3 -> all outputs reset values immediately; a fresh job of act=[-128]*4, wgt=[-128]*4 (dense) -> 65536.
